jk_bank_ctrl: RTL
=================

Name: jk_bank_ctrl

Overview:
- Command-driven sequencer for a bank of WIDTH JK flip-flops.
- Accepts one command per valid/ready handshake and translates it into per-bit J/K drive: set, clear, toggle, load, or a multi-cycle synchronous binary count.
- Sits between a register/control front-end and the flip-flop bank. The bank is instantiated internally and its state is exposed on q.

Parameters:
- WIDTH, 8, number of JK cells in the bank.
- CNT_W, 8, width of the count-length field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  opcode: 0 NOP, 1 SET, 2 CLR, 3 TOG, 4 LOAD, 5 COUNT, 6/7 illegal.
- cmd_data  in  WIDTH  bit mask (SET/CLR/TOG) or load value (LOAD).
- cmd_len  in  CNT_W  number of increment steps (COUNT only).
- abort  in  1  stop an in-progress COUNT.
- q  out  WIDTH  bank state.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse with done for an illegal opcode.
- ovf  out  1  one-cycle pulse with done if the count wrapped at least once.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on rising clk.
- Reset values:
  - q=0, state=IDLE.
  - cmd_ready=0 while rst=1, then 1 in the first cycle after release.
  - busy=0, done=0, err=0, ovf=0.
  - Step counter = 0; internal J=K=0.
- Reset asserted mid-command (APPLY or COUNT) discards the command immediately, with no done pulse.
- FSM states: IDLE, APPLY, COUNT, DONE.
- IDLE:
  - cmd_ready=1, J=K=0, so the bank holds.
  - On cmd_valid&&cmd_ready, latch op/data/len.
  - Op 5 with len≠0 → COUNT. Every other op → APPLY.
- APPLY (one cycle), per-bit J/K drive:
  - NOP: J=K=0.
  - SET: J=data, K=0.
  - CLR: J=0, K=data.
  - TOG: J=K=data.
  - LOAD: J=data, K=~data.
  - COUNT with len=0: J=K=0.
  - Illegal op: J=K=0, err flagged.
  - The bank updates at the end of the cycle → DONE.
- COUNT:
  - Per bit i: J_i=K_i=AND(q[i-1:0]), with bit 0 always toggling. Each cycle therefore adds 1 mod 2^WIDTH.
  - The step counter loads len at accept and decrements once per step.
  - On the last step (counter==1) → DONE.
  - A step from all-ones to 0 sets the sticky ovf_flag.
  - If abort=1 in a COUNT cycle, J=K=0 in that cycle (no step) → DONE.
- DONE (one cycle):
  - done=1. err and ovf reflect the latched flags, which clear on exit.
  - cmd_ready=0 → IDLE.
- Latency from accept edge:
  - APPLY ops: new q visible 1 cycle later; done in cycle 2.
  - COUNT n: q advances once per cycle for n cycles; done in cycle n+1.
- Back-to-back commands: the next accept is no earlier than the cycle after DONE.
- cmd_ready=0 in APPLY, COUNT and DONE. Inputs other than abort are ignored outside IDLE.
- abort is ignored outside COUNT.
- busy = (state != IDLE).
- Step-counter arithmetic is unsigned CNT_W bits and never underflows, because the transition to DONE occurs at 1.

Decomposition:
- Shared package jk_pkg:
  - Opcode constants: OP_NOP, OP_SET, OP_CLR, OP_TOG, OP_LOAD, OP_COUNT.
  - State encoding constants: S_IDLE, S_APPLY, S_COUNT, S_DONE.
- Sub-module jk_cell:
  - Single JK flip-flop with synchronous active-high rst, ports clk, rst, J, K, Q.
  - Hold / reset / set / toggle semantics; reset Q=0.
  - Instantiated WIDTH times via generate.
  - The controller contains only the FSM, step counter, flags and J/K decode.

Test Plan:
- Reset, then SET data=0xA5 → q=0xA5 one cycle after accept. Next cycle: done=1, err=0, cmd_ready=0. Following cycle cmd_ready=1.
- From q=0xA5: CLR 0x0F → 0xA0; TOG 0xFF → 0x5F; LOAD 0x3C → 0x3C; NOP → 0x3C.
- LOAD 0xFD, then COUNT len=4 → q steps FE, FF, 00, 01. done in cycle 5 after accept with ovf=1. COUNT len=0 → q unchanged, done in cycle 2, ovf=0.
- COUNT len=200 from q=0, with abort asserted in the 10th COUNT cycle → q=9, then done next cycle, ovf=0, no further change.
- cmd_op=6 with data=0xFF → q unchanged, err=1 with done. cmd_valid held high through busy → exactly one accept per IDLE visit.
- rst=1 during COUNT (after 3 steps from 0) → next cycle q=0, busy=0, done=0. After release, cmd_ready=1 and a new SET 0x01 completes normally.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared opcode and state encodings for the JK bank controller.
package jk_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_SET   = 3'd1;
  localparam logic [2:0] OP_CLR   = 3'd2;
  localparam logic [2:0] OP_TOG   = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;
  localparam logic [2:0] OP_COUNT = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= OP_COUNT;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: hold / clear / set / toggle, synchronous active-high reset.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        2'b01:   Q <= 1'b0;
        2'b10:   Q <= 1'b1;
        2'b11:   Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer translating set/clear/toggle/load/count commands into
// per-bit J/K drive for an internal bank of WIDTH JK flip-flops.
module jk_bank_ctrl
  import jk_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ovf
);

  state_e           state;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] step_cnt;
  logic             err_flag;
  logic             ovf_flag;

  logic [WIDTH-1:0] j_drv;
  logic [WIDTH-1:0] k_drv;
  logic [WIDTH-1:0] carry;
  logic             accept;
  logic             wrap;
  logic             last_step;

  assign accept    = cmd_valid && cmd_ready;
  assign wrap      = &q;
  assign last_step = (step_cnt == CNT_W'(1));
  assign busy      = (state != S_IDLE);

  // Counter toggle enables: bit i toggles when all lower bits are one.
  always_comb begin
    logic [WIDTH-1:0] low;
    low   = '0;
    carry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = &(q | ~low);
      low[i]   = 1'b1;
    end
  end

  always_comb begin
    j_drv = '0;
    k_drv = '0;
    case (state)
      S_APPLY: begin
        case (op_r)
          OP_SET: begin
            j_drv = data_r;
          end
          OP_CLR: begin
            k_drv = data_r;
          end
          OP_TOG: begin
            j_drv = data_r;
            k_drv = data_r;
          end
          OP_LOAD: begin
            j_drv = data_r;
            k_drv = ~data_r;
          end
          default: begin
            j_drv = '0;
            k_drv = '0;
          end
        endcase
      end
      S_COUNT: begin
        if (!abort) begin
          j_drv = carry;
          k_drv = carry;
        end
      end
      default: begin
        j_drv = '0;
        k_drv = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ovf       <= 1'b0;
      op_r      <= OP_NOP;
      step_cnt  <= '0;
      err_flag  <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      ovf  <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            op_r      <= cmd_op;
            data_r    <= cmd_data;
            step_cnt  <= cmd_len;
            err_flag  <= !op_is_legal(cmd_op);
            ovf_flag  <= 1'b0;
            cmd_ready <= 1'b0;
            if (cmd_op == OP_COUNT && cmd_len != '0) begin
              state <= S_COUNT;
            end else begin
              state <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          state <= S_DONE;
          done  <= 1'b1;
          err   <= err_flag;
          ovf   <= ovf_flag;
        end
        S_COUNT: begin
          if (abort) begin
            state <= S_DONE;
            done  <= 1'b1;
            ovf   <= ovf_flag;
          end else begin
            step_cnt <= step_cnt - CNT_W'(1);
            if (wrap) begin
              ovf_flag <= 1'b1;
            end
            // The wrap on the final step must still reach the ovf pulse.
            if (last_step) begin
              state <= S_DONE;
              done  <= 1'b1;
              ovf   <= ovf_flag | wrap;
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          err_flag  <= 1'b0;
          ovf_flag  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .J   (j_drv[i]),
      .K   (k_drv[i]),
      .Q   (q[i])
    );
  end

endmodule
